cam_register_loader: RTL and testbench
======================================

// Module: cam_register_loader
// PURPOSE
//  Boot-time OV5640 register loader. On a valid/ready init handshake it walks a
//  24-bit ROM of {reg_addr[15:0], value[7:0]} entries and writes each entry to the
//  camera over I2C (7-bit device address, 16-bit register address, 1 data byte).
//  Sits between the config ROM (single-port BRAM, 2-cycle read) and the SCCB/I2C pins.
// PARAMETERS
//  DEVICE_ADDR  7'h3C  I2C slave address; address byte on the bus = {DEVICE_ADDR,1'b0}
//  CLK_DIV      63     clk cycles per quarter SCL period (~397 kHz SCL at 100 MHz)
//  ROM_DEPTH    256    ROM entries; bram_addr width = $clog2(ROM_DEPTH) = 8
// PORTS
//  clk_in      in   1   system clock
//  rst_in      in   1   synchronous, active-high reset
//  init_valid  in   1   request to run the register sequence
//  init_ready  out  1   high when idle; handshake fires on init_valid && init_ready
//  scl_i       in   1   SCL line level (wired-AND of all drivers)
//  scl_o       out  1   0 = pull SCL low, 1 = release
//  scl_t       out  1   tristate enable, equals scl_o (1 = Hi-Z)
//  sda_i       in   1   SDA line level
//  sda_o       out  1   0 = pull SDA low, 1 = release
//  sda_t       out  1   equals sda_o
//  bram_dout   in   24  ROM data {reg_addr[15:0], value[7:0]}, valid 2 cycles after bram_addr
//  bram_addr   out  8   ROM address, registered
// BEHAVIOUR
//  - Reset: init_ready=1, bram_addr=0, scl_o=scl_t=1, sda_o=sda_t=1, state IDLE.
//  - States: IDLE -> FETCH -> CHECK -> START -> BYTE(x4) -> STOP -> GAP -> FETCH ... -> IDLE.
//  - IDLE: init_ready=1. On init_valid&&init_ready: idx=0, init_ready=0 next cycle, go FETCH.
//    init_valid while busy is ignored.
//  - FETCH: drive bram_addr=idx, wait 3 cycles (1 addr reg + 2 BRAM latency), latch bram_dout.
//  - CHECK: entry==24'hFFFFFF is end marker -> IDLE (no bus activity).
//  - Bit timing: each bit = 4 quarters of CLK_DIV cycles: Q0 SCL low, set SDA; Q1 SCL low;
//    Q2 release SCL, counter frozen while scl_i==0 (clock stretching); Q3 SCL high.
//  - START: SDA released, SCL released; after one quarter pull SDA low; after another pull SCL low.
//  - BYTE: 8 bits MSB first, then ACK bit with SDA released, sda_i sampled at end of Q3.
//    Bytes in order: {DEVICE_ADDR,0}, reg_addr[15:8], reg_addr[7:0], value.
//  - NACK (sda_i==1 at ACK) on any byte: skip remaining bytes, go STOP.
//  - STOP: SCL low, SDA low; release SCL (honour stretching); after one quarter release SDA.
//  - GAP: bus idle (both released) one full bit period; then idx++.
//  - idx==ROM_DEPTH-1 completed (would wrap): -> IDLE; idx never wraps to 0.
//  - Return to IDLE: init_ready=1 next cycle; a new handshake restarts from entry 0.
//  - rst_in mid-transfer: immediate return to reset values (both lines released).
//  - SCL/SDA outputs change only while SCL is driven low, except START/STOP edges.
// CONFIGURATION
//  CAM_REG_NACK_RETRY_EN defined: after a NACKed transaction's STOP+GAP, the same entry
//    is retried up to 3 more times; after the 4th NACK, advance to the next entry.
//  Not defined: a NACKed entry is never retried; advance to the next entry.
// TESTING
//  1 Reset: after rst_in pulse -> init_ready=1, scl_o=sda_o=1, bram_addr=0, no bus edges.
//  2 ROM[0]=24'h300882, ROM[1]=24'hFFFFFF, slave @0x3C; pulse init_valid 1 cycle ->
//    slave receives 30,08,82 (last on 82) after addr 0x78 ACK; then init_ready=1.
//  3 ROM[0]=24'hFFFFFF -> no START generated, init_ready back to 1 within 10 cycles.
//  4 Slave address set to 0x21 (NACK) -> START, 0x78, NACK, STOP; without retry macro
//    1 transaction/entry, with CAM_REG_NACK_RETRY_EN 4 transactions/entry.
//  5 Slave holds SCL low 500 cycles in a bit -> master waits; byte still 0x30, no bit lost.
//  6 init_valid held high during sequence -> no restart; full ROM of 255 writes then
//    final entry 255 written and sequence ends without wrap.

Source files
------------

// File: rtl/cam_register_loader.sv
// rtl/cam_register_loader.sv - boot-time OV5640 register loader (ROM walk to I2C writes)
//
// Ports:
//   clk_in, rst_in         system clock, synchronous active-high reset
//   init_valid/init_ready  start handshake; init_ready is high only while idle
//   scl_i/scl_o/scl_t      SCL line level in, open-drain drive out (0 = pull low), tristate = scl_o
//   sda_i/sda_o/sda_t      SDA line level in, open-drain drive out (0 = pull low), tristate = sda_o
//   bram_dout/bram_addr    config ROM {reg_addr[15:0], value[7:0]}, data 2 cycles after address
//
// Optional feature macro: CAM_REG_NACK_RETRY_EN - a NACKed entry is retried up to 3 more
// times before the loader moves on; without it a NACKed entry is skipped.
module cam_register_loader #(
    parameter logic [6:0] DEVICE_ADDR = 7'h3C,
    parameter int         CLK_DIV     = 63,
    parameter int         ROM_DEPTH   = 256
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         init_valid,
    output logic                         init_ready,
    input  logic                         scl_i,
    output logic                         scl_o,
    output logic                         scl_t,
    input  logic                         sda_i,
    output logic                         sda_o,
    output logic                         sda_t,
    input  logic [23:0]                  bram_dout,
    output logic [$clog2(ROM_DEPTH)-1:0] bram_addr
);

    localparam int ADDR_W = $clog2(ROM_DEPTH);
    localparam int CNT_W  = $clog2(CLK_DIV + 1);
`ifdef CAM_REG_NACK_RETRY_EN
    localparam logic [1:0] MAX_RETRY = 2'd3;
`else
    localparam logic [1:0] MAX_RETRY = 2'd0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_START,
        S_BYTE,
        S_STOP,
        S_GAP
    } state_t;

    state_t              state, state_nxt;
    logic [1:0]          qph, qph_nxt;          // quarter of the current bit
    logic [CNT_W-1:0]    qcnt, qcnt_nxt;        // clk cycles inside the quarter
    logic [3:0]          bit_idx, bit_nxt;      // 0..7 data bits, 8 = ACK slot
    logic [1:0]          byte_idx, byte_nxt;
    logic [ADDR_W-1:0]   idx, idx_nxt;
    logic [1:0]          retry_cnt, retry_nxt;
    logic                nacked, nacked_nxt;
    logic [23:0]         entry, entry_nxt;
    logic [1:0]          fetch_cnt, fetch_nxt;
    logic                scl_q, scl_nxt;
    logic                sda_q, sda_nxt;
    logic                ready_q, ready_nxt;
    logic [ADDR_W-1:0]   addr_nxt;

    logic                q_end, stall, tick, bit_val;
    logic [7:0]          cur_byte;

    assign init_ready = ready_q;
    assign scl_o      = scl_q;
    assign scl_t      = scl_q;
    assign sda_o      = sda_q;
    assign sda_t      = sda_q;

    // While SCL is released in quarter 2 a slave may hold it low; the quarter
    // counter waits for the line to actually rise before timing the high phase.
    assign q_end = (qcnt == CNT_W'(CLK_DIV - 1));
    assign stall = (qph == 2'd2) && !scl_i && (state == S_BYTE || state == S_STOP);
    assign tick  = q_end && !stall;

    always_comb begin
        cur_byte = entry[7:0];
        case (byte_idx)
            2'd0:    cur_byte = {DEVICE_ADDR, 1'b0};
            2'd1:    cur_byte = entry[23:16];
            2'd2:    cur_byte = entry[15:8];
            default: cur_byte = entry[7:0];
        endcase
    end

    assign bit_val = (bit_idx == 4'd8) ? 1'b1 : cur_byte[3'd7 - bit_idx[2:0]];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= S_IDLE;
            qph       <= '0;
            qcnt      <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            idx       <= '0;
            retry_cnt <= '0;
            nacked    <= 1'b0;
            entry     <= '0;
            fetch_cnt <= '0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            ready_q   <= 1'b1;
            bram_addr <= '0;
        end else begin
            state     <= state_nxt;
            qph       <= qph_nxt;
            qcnt      <= qcnt_nxt;
            bit_idx   <= bit_nxt;
            byte_idx  <= byte_nxt;
            idx       <= idx_nxt;
            retry_cnt <= retry_nxt;
            nacked    <= nacked_nxt;
            entry     <= entry_nxt;
            fetch_cnt <= fetch_nxt;
            scl_q     <= scl_nxt;
            sda_q     <= sda_nxt;
            ready_q   <= ready_nxt;
            bram_addr <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        qph_nxt    = qph;
        qcnt_nxt   = qcnt;
        bit_nxt    = bit_idx;
        byte_nxt   = byte_idx;
        idx_nxt    = idx;
        retry_nxt  = retry_cnt;
        nacked_nxt = nacked;
        entry_nxt  = entry;
        fetch_nxt  = fetch_cnt;
        scl_nxt    = scl_q;
        sda_nxt    = sda_q;
        addr_nxt   = bram_addr;

        if (state == S_START || state == S_BYTE || state == S_STOP || state == S_GAP) begin
            if (tick) begin
                qcnt_nxt = '0;
                qph_nxt  = qph + 2'd1;
            end else if (!stall) begin
                qcnt_nxt = qcnt + CNT_W'(1);
            end
        end

        case (state)
            S_IDLE: begin
                scl_nxt = 1'b1;
                sda_nxt = 1'b1;
                if (init_valid && ready_q) begin
                    idx_nxt   = '0;
                    retry_nxt = '0;
                    fetch_nxt = '0;
                    state_nxt = S_FETCH;
                end
            end

            // Address goes out on the first cycle, data is back three cycles later.
            S_FETCH: begin
                addr_nxt  = idx;
                fetch_nxt = fetch_cnt + 2'd1;
                if (fetch_cnt == 2'd3) begin
                    entry_nxt = bram_dout;
                    state_nxt = S_CHECK;
                end
            end

            S_CHECK: begin
                qph_nxt    = '0;
                qcnt_nxt   = '0;
                bit_nxt    = '0;
                byte_nxt   = '0;
                nacked_nxt = 1'b0;
                state_nxt  = (entry == 24'hFFFFFF) ? S_IDLE : S_START;
            end

            S_START: begin
                if (tick && qph == 2'd0) begin
                    sda_nxt = 1'b0;
                end else if (tick && qph == 2'd1) begin
                    scl_nxt   = 1'b0;
                    qph_nxt   = '0;
                    state_nxt = S_BYTE;
                end
            end

            // SDA moves one cycle after SCL has fallen, never on the same edge.
            S_BYTE: begin
                if (qph == 2'd0 && qcnt == '0) begin
                    sda_nxt = bit_val;
                end
                if (tick && qph == 2'd1) begin
                    scl_nxt = 1'b1;
                end
                if (tick && qph == 2'd3) begin
                    scl_nxt = 1'b0;
                    if (bit_idx == 4'd8) begin
                        bit_nxt = '0;
                        if (sda_i) begin
                            nacked_nxt = 1'b1;
                            state_nxt  = S_STOP;
                        end else if (byte_idx == 2'd3) begin
                            state_nxt = S_STOP;
                        end else begin
                            byte_nxt = byte_idx + 2'd1;
                        end
                    end else begin
                        bit_nxt = bit_idx + 4'd1;
                    end
                end
            end

            S_STOP: begin
                if (qph == 2'd0 && qcnt == '0) begin
                    sda_nxt = 1'b0;
                end
                if (tick && qph == 2'd1) begin
                    scl_nxt = 1'b1;
                end
                if (tick && qph == 2'd2) begin
                    sda_nxt   = 1'b1;
                    qph_nxt   = '0;
                    state_nxt = S_GAP;
                end
            end

            S_GAP: begin
                scl_nxt = 1'b1;
                sda_nxt = 1'b1;
                if (tick && qph == 2'd3) begin
                    fetch_nxt = '0;
                    if (nacked && retry_cnt != MAX_RETRY) begin
                        retry_nxt = retry_cnt + 2'd1;
                        state_nxt = S_FETCH;
                    end else if (idx == ADDR_W'(ROM_DEPTH - 1)) begin
                        state_nxt = S_IDLE;
                    end else begin
                        idx_nxt   = idx + ADDR_W'(1);
                        retry_nxt = '0;
                        state_nxt = S_FETCH;
                    end
                end
            end

            default: state_nxt = S_IDLE;
        endcase

        ready_nxt = (state_nxt == S_IDLE);
    end

endmodule

// File: tb/tb_cam_register_loader.sv
// tb/tb_cam_register_loader.sv - self-checking bench for cam_register_loader with I2C slave and ROM models
module tb_cam_register_loader;

    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);
`ifdef CAM_REG_NACK_RETRY_EN
    localparam int ATTEMPTS = 4;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic          clk_in     = 1'b0;
    logic          rst_in     = 1'b1;
    logic          init_valid = 1'b0;
    logic          init_ready;
    logic          scl_o, scl_t, sda_o, sda_t;
    logic          scl_line, sda_line;
    logic [23:0]   bram_dout;
    logic [AW-1:0] bram_addr;

    logic          scl_hold = 1'b0;
    logic          sda_low  = 1'b0;

    assign scl_line = scl_o & ~scl_hold;
    assign sda_line = sda_o & ~sda_low;

    cam_register_loader #(
        .DEVICE_ADDR (7'h3C),
        .CLK_DIV     (2),
        .ROM_DEPTH   (DEPTH)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .init_valid (init_valid),
        .init_ready (init_ready),
        .scl_i      (scl_line),
        .scl_o      (scl_o),
        .scl_t      (scl_t),
        .sda_i      (sda_line),
        .sda_o      (sda_o),
        .sda_t      (sda_t),
        .bram_dout  (bram_dout),
        .bram_addr  (bram_addr)
    );

    always #5 clk_in = ~clk_in;

    // Config ROM: two-stage read pipeline.
    logic [23:0] rom [0:DEPTH-1];
    logic [23:0] rom_d1;
    always @(posedge clk_in) begin
        rom_d1    <= rom[bram_addr];
        bram_dout <= rom_d1;
    end

    // I2C slave model observing the wired-AND lines.
    logic [6:0]  slave_addr = 7'h3C;
    bit          stretch_en = 1'b0;
    int          starts = 0, stops = 0, scl_edges = 0, stretch_cycles = 0, hold_cnt = 0;
    int          bitcnt = 0, byte_no = 0;
    logic        prev_scl = 1'b1, prev_sda = 1'b1, ack_phase = 1'b0, addressed = 1'b0;
    logic [7:0]  shreg = '0, b1 = '0, b2 = '0;
    logic [7:0]  addr_bytes[$];
    logic [23:0] writes[$];

    always @(negedge clk_in) begin
        prev_scl <= scl_line;
        prev_sda <= sda_line;
        if (scl_o && !scl_line) stretch_cycles <= stretch_cycles + 1;
        if (scl_line !== prev_scl) scl_edges <= scl_edges + 1;
        if (hold_cnt > 0) begin
            hold_cnt <= hold_cnt - 1;
            if (hold_cnt == 1) scl_hold <= 1'b0;
        end
        if (rst_in) begin
            sda_low   <= 1'b0;
            scl_hold  <= 1'b0;
            hold_cnt  <= 0;
            ack_phase <= 1'b0;
            bitcnt    <= 0;
        end else if (prev_scl && scl_line && prev_sda && !sda_line) begin
            starts    <= starts + 1;
            bitcnt    <= 0;
            byte_no   <= 0;
            ack_phase <= 1'b0;
            addressed <= 1'b0;
        end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
            stops <= stops + 1;
        end else if (!prev_scl && scl_line) begin
            if (!ack_phase) begin
                shreg  <= {shreg[6:0], sda_line};
                bitcnt <= bitcnt + 1;
            end
        end else if (prev_scl && !scl_line) begin
            if (ack_phase) begin
                ack_phase <= 1'b0;
                sda_low   <= 1'b0;
                bitcnt    <= 0;
            end else if (bitcnt == 8) begin
                ack_phase <= 1'b1;
                byte_no   <= byte_no + 1;
                case (byte_no)
                    0: begin
                        addr_bytes.push_back(shreg);
                        addressed <= (shreg == {slave_addr, 1'b0});
                        sda_low   <= (shreg == {slave_addr, 1'b0});
                    end
                    1: begin b1 <= shreg; sda_low <= addressed; end
                    2: begin b2 <= shreg; sda_low <= addressed; end
                    default: begin
                        if (addressed) writes.push_back({b1, b2, shreg});
                        sda_low <= addressed;
                    end
                endcase
            end else if (stretch_en && byte_no == 1 && bitcnt == 3) begin
                scl_hold <= 1'b1;
                hold_cnt <= 500;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshake, then wait (bounded) for the loader to report idle again.
    task automatic run_seq(input bit hold_valid, input int budget, output int cycles);
        @(negedge clk_in);
        init_valid = 1'b1;
        @(negedge clk_in);
        if (!hold_valid) init_valid = 1'b0;
        cycles = 1;
        while (!init_ready && cycles < budget) begin
            @(negedge clk_in);
            cycles++;
        end
        init_valid = 1'b0;
        check_eq("seq_done_ready", init_ready, 1'b1);
    endtask

    // Reference: the slave should see every entry up to (not including) the first end marker.
    task automatic check_writes(input string tag, input int base);
        logic [23:0] exp[$];
        int got_n;
        for (int i = 0; i < DEPTH; i++) begin
            if (rom[i] == 24'hFFFFFF) break;
            exp.push_back(rom[i]);
        end
        got_n = writes.size() - base;
        check_eq({tag, "_count"}, got_n, exp.size());
        for (int i = 0; i < exp.size() && i < got_n; i++)
            check_eq({tag, "_data"}, writes[base + i], exp[i]);
    endtask

    task automatic fill_rom(input int marker_pos);
        for (int i = 0; i < DEPTH; i++)
            rom[i] = (i == marker_pos) ? 24'hFFFFFF : 24'($urandom_range(0, 24'hFFFFFE));
    endtask

    initial begin
        int cyc, s0, p0, w0, a0, e0, st0;

        for (int i = 0; i < DEPTH; i++) rom[i] = 24'hFFFFFF;
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Reset state and a quiet bus
        check_eq("rst_ready", init_ready, 1'b1);
        check_eq("rst_scl_o", scl_o, 1'b1);
        check_eq("rst_sda_o", sda_o, 1'b1);
        check_eq("rst_scl_t", scl_t, 1'b1);
        check_eq("rst_sda_t", sda_t, 1'b1);
        check_eq("rst_addr", bram_addr, 0);
        e0 = scl_edges;
        repeat (40) @(negedge clk_in);
        check_eq("rst_no_edges", scl_edges - e0, 0);

        // Single entry then end marker
        rom[0] = 24'h300882;
        rom[1] = 24'hFFFFFF;
        s0 = starts; p0 = stops; w0 = writes.size(); a0 = addr_bytes.size();
        run_seq(1'b0, 5000, cyc);
        check_writes("one_entry", w0);
        check_eq("one_addr_byte", addr_bytes.size() > a0 ? addr_bytes[a0] : 8'h00, 8'h78);
        check_eq("one_starts", starts - s0, 1);
        check_eq("one_stops", stops - p0, 1);

        // End marker first: no bus activity, fast return
        rom[0] = 24'hFFFFFF;
        s0 = starts;
        run_seq(1'b0, 100, cyc);
        check_eq("marker_fast", cyc <= 10, 1'b1);
        check_eq("marker_no_start", starts - s0, 0);

        // Absent slave: every transaction NACKed on the address byte
        fill_rom(3);
        slave_addr = 7'h21;
        s0 = starts; p0 = stops; w0 = writes.size(); a0 = addr_bytes.size();
        run_seq(1'b0, 8000, cyc);
        check_eq("nack_starts", starts - s0, 3 * ATTEMPTS);
        check_eq("nack_stops", stops - p0, 3 * ATTEMPTS);
        check_eq("nack_writes", writes.size() - w0, 0);
        for (int i = a0; i < addr_bytes.size(); i++)
            check_eq("nack_addr_byte", addr_bytes[i], 8'h78);
        slave_addr = 7'h3C;

        // Clock stretching inside the register-address high byte
        rom[0] = 24'h300882;
        rom[1] = 24'hFFFFFF;
        stretch_en = 1'b1;
        w0 = writes.size(); st0 = stretch_cycles;
        run_seq(1'b0, 5000, cyc);
        stretch_en = 1'b0;
        check_writes("stretch", w0);
        check_eq("stretch_waited", (stretch_cycles - st0) >= 480, 1'b1);

        // Full ROM, init_valid held the whole time, last entry written without wrap
        fill_rom(-1);
        w0 = writes.size(); s0 = starts;
        run_seq(1'b1, 40000, cyc);
        check_writes("full_rom", w0);
        check_eq("full_rom_starts", starts - s0, DEPTH);
        s0 = starts;
        repeat (30) @(negedge clk_in);
        check_eq("full_rom_stays_idle", starts - s0, 0);
        check_eq("full_rom_ready", init_ready, 1'b1);

        // Random ROMs with random end-marker positions
        for (int t = 0; t < 4; t++) begin
            fill_rom($urandom_range(0, 5));
            w0 = writes.size();
            run_seq(1'b0, 8000, cyc);
            check_writes("rand_rom", w0);
        end

        // Reset in the middle of a transfer, then a clean rerun from entry 0
        fill_rom(2);
        @(negedge clk_in);
        init_valid = 1'b1;
        @(negedge clk_in);
        init_valid = 1'b0;
        repeat (150) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check_eq("midrst_ready", init_ready, 1'b1);
        check_eq("midrst_scl", scl_o, 1'b1);
        check_eq("midrst_sda", sda_o, 1'b1);
        check_eq("midrst_addr", bram_addr, 0);
        repeat (10) @(negedge clk_in);
        w0 = writes.size();
        run_seq(1'b0, 8000, cyc);
        check_writes("after_rst", w0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
